seq_sym_serializer: RTL and testbench

//  Upstream feeder for the 2-bit-symbol sequence detector (inputs A, B; output Z).

---
 rtl/seq_dect_pkg.sv | 20 ++
 rtl/seq_word_hold.sv | 44 ++++
 rtl/seq_sym_serializer.sv | 139 +++++++++++++
 tb/tb_seq_sym_serializer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seq_dect_pkg.sv
// Shared types and defaults for the 2-bit-symbol sequence detector front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_dect_pkg;

    // One {A,B} symbol as seen by the detector.
    typedef logic [1:0] sym_t;

    // Symbol driven while the serializer has nothing to shift.
    localparam sym_t IDLE_SYM = 2'b00;

    // Default number of symbols packed into one pattern word.
    localparam int SYMS_PER_WORD = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/seq_word_hold.sv
// One-entry holding register that parks a word while the shifter is busy.
// Latency: written on one edge, readable from the next; ready updates one edge later.
// Backpressure: ready is registered and low whenever the entry is (or is becoming) occupied.
//
// Ports:
//   clk, clr        clock, asynchronous active-low reset
//   wr, wr_data     capture wr_data into the entry (caller only asserts when ready)
//   rd              release the entry (caller only asserts when valid)
//   data, valid     held word and its occupancy flag
//   ready           registered "entry free" flag; held low during reset and for the first edge after it
module seq_word_hold #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         rd,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         ready
);

    logic valid_n;

    // Write and release never coincide: a write needs the entry empty, a release needs it full.
    assign valid_n = wr | (valid & ~rd);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data  <= '0;
            valid <= 1'b0;
            ready <= 1'b0;
        end else begin
            if (wr) begin
                data <= wr_data;
            end
            valid <= valid_n;
            // Ready mirrors the entry occupancy after this edge, so it never depends on word_valid.
            ready <= ~valid_n;
        end
    end

endmodule

// File: rtl/seq_sym_serializer.sv
// Serializes 16-bit pattern words into one {A,B} symbol per clock, MSB pair first, idle symbol when starved.
// Latency: a word accepted on an edge shows its first symbol right after that same edge.
// Backpressure: word_ready = hold entry free (registered); the source holds word_in while ready is low.
//
// Ports:
//   clk, clr                clock, asynchronous active-low reset
//   word_in, word_valid     pattern word offered by the source
//   word_ready              block will take word_in on the next rising edge
//   A, B                    registered symbol to the detector
//   sym_valid, sym_first    A/B carry a word symbol / the first symbol of a word
//   busy                    shifter active or hold entry occupied
module seq_sym_serializer
    import seq_dect_pkg::sym_t;
    import seq_dect_pkg::ser_state_t;
    import seq_dect_pkg::S_IDLE;
    import seq_dect_pkg::S_SHIFT;
#(
    parameter int   SYMS_PER_WORD = 8,
    parameter sym_t IDLE_SYM      = seq_dect_pkg::IDLE_SYM
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [2*SYMS_PER_WORD-1:0] word_in,
    input  logic                       word_valid,
    output logic                       word_ready,
    output logic                       A,
    output logic                       B,
    output logic                       sym_valid,
    output logic                       sym_first,
    output logic                       busy
);

    localparam int W     = 2 * SYMS_PER_WORD;
    localparam int IDX_W = $clog2(SYMS_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS_PER_WORD - 1);

    ser_state_t       state, state_n;
    logic [W-1:0]     sr, sr_n;
    logic [IDX_W-1:0] sym_idx, sym_idx_n;
    sym_t             sym_q, sym_n;
    logic             vld_q, vld_n;
    logic             first_q, first_n;

    logic             accept;
    logic             h_wr, h_rd, h_valid;
    logic [W-1:0]     h_data;
    logic             ld_en;
    logic [W-1:0]     ld_word;

    assign accept = word_valid & word_ready;

    seq_word_hold #(.W(W)) u_hold (
        .clk     (clk),
        .clr     (clr),
        .wr      (h_wr),
        .wr_data (word_in),
        .rd      (h_rd),
        .data    (h_data),
        .valid   (h_valid),
        .ready   (word_ready)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= S_IDLE;
            sr      <= '0;
            sym_idx <= '0;
            sym_q   <= IDLE_SYM;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            sym_idx <= sym_idx_n;
            sym_q   <= sym_n;
            vld_q   <= vld_n;
            first_q <= first_n;
        end
    end

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        sym_idx_n = sym_idx;
        sym_n     = sym_q;
        vld_n     = vld_q;
        first_n   = 1'b0;
        h_wr      = 1'b0;
        h_rd      = 1'b0;
        ld_en     = 1'b0;
        ld_word   = word_in;

        case (state)
            S_IDLE: begin
                ld_en = accept;
            end
            default: begin
                if (sym_idx == LAST_IDX) begin
                    // Last symbol is on the wire: chain the next word without a gap.
                    // The hold entry has priority; a fresh accept can only happen when it is empty.
                    if (h_valid) begin
                        ld_en   = 1'b1;
                        ld_word = h_data;
                        h_rd    = 1'b1;
                    end else if (accept) begin
                        ld_en = 1'b1;
                    end else begin
                        state_n   = S_IDLE;
                        sym_n     = IDLE_SYM;
                        vld_n     = 1'b0;
                        sym_idx_n = '0;
                    end
                end else begin
                    sym_n     = sr[W-1 -: 2];
                    sr_n      = {sr[W-3:0], 2'b00};
                    sym_idx_n = sym_idx + 1'b1;
                    h_wr      = accept;
                end
            end
        endcase

        // The top pair goes straight to the output register; the shifter keeps the remainder.
        if (ld_en) begin
            state_n   = S_SHIFT;
            sym_n     = ld_word[W-1 -: 2];
            sr_n      = {ld_word[W-3:0], 2'b00};
            sym_idx_n = '0;
            vld_n     = 1'b1;
            first_n   = 1'b1;
        end
    end

    assign A         = sym_q[1];
    assign B         = sym_q[0];
    assign sym_valid = vld_q;
    assign sym_first = first_q;
    assign busy      = (state == S_SHIFT) | h_valid;

endmodule

// File: tb/tb_seq_sym_serializer.sv
// Directed bench for seq_sym_serializer: reset, single word, back-to-back, starvation, backpressure, mid-word reset.
// Latency: n/a.
// Backpressure: source holds word_in/word_valid until an accepting edge.
module tb_seq_sym_serializer;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        A, B;
    logic        sym_valid, sym_first, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_sym_serializer dut (
        .clk        (clk),
        .clr        (clr),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .A          (A),
        .B          (B),
        .sym_valid  (sym_valid),
        .sym_first  (sym_first),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_sym(input string tag, input logic [1:0] s, input logic v, input logic f);
        chk({tag, ".sym"},   {14'd0, A, B},         {14'd0, s});
        chk({tag, ".valid"}, {15'd0, sym_valid},    {15'd0, v});
        chk({tag, ".first"}, {15'd0, sym_first},    {15'd0, f});
    endtask

    task automatic chk_idle(input string tag, input logic rdy);
        chk_sym(tag, 2'b00, 1'b0, 1'b0);
        chk({tag, ".busy"},  {15'd0, busy},       16'd0);
        chk({tag, ".ready"}, {15'd0, word_ready}, {15'd0, rdy});
    endtask

    // Called at the negedge showing symbol 0; walks the remaining symbols of w.
    task automatic chk_word(input string tag, input logic [15:0] w);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk_sym($sformatf("%s[%0d]", tag, i), w[15-2*i -: 2], 1'b1, i == 0);
        end
    endtask

    logic [15:0] ws [3];
    logic [15:0] cur;

    initial begin
        // ---- reset with word_valid already high: nothing taken until the edge after release
        clr        = 1'b0;
        word_valid = 1'b1;
        word_in    = 16'b01_11_00_11_10_00_11_10;
        @(negedge clk);
        chk_idle("rst", 1'b0);
        clr = 1'b1;
        @(negedge clk);
        chk_idle("rel", 1'b1);

        // ---- single word
        @(negedge clk);
        word_valid = 1'b0;
        chk("w1.busy", {15'd0, busy}, 16'd1);
        chk_sym("w1.s0", 2'b01, 1'b1, 1'b1);
        @(negedge clk); chk_sym("w1.s1", 2'b11, 1'b1, 1'b0);
        @(negedge clk); chk_sym("w1.s2", 2'b00, 1'b1, 1'b0);
        @(negedge clk); chk_sym("w1.s3", 2'b11, 1'b1, 1'b0);
        @(negedge clk); chk_sym("w1.s4", 2'b10, 1'b1, 1'b0);
        @(negedge clk); chk_sym("w1.s5", 2'b00, 1'b1, 1'b0);
        @(negedge clk); chk_sym("w1.s6", 2'b11, 1'b1, 1'b0);
        @(negedge clk); chk_sym("w1.s7", 2'b10, 1'b1, 1'b0);
        @(negedge clk); chk_idle("w1.end", 1'b1);

        // ---- two words back-to-back
        word_valid = 1'b1;
        word_in    = 16'hFFFF;
        @(negedge clk);
        word_in = 16'h0000;
        chk_sym("b2b.a0", 2'b11, 1'b1, 1'b1);
        chk("b2b.rdy0", {15'd0, word_ready}, 16'd1);
        @(negedge clk);
        word_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            if (i > 1) @(negedge clk);
            chk_sym($sformatf("b2b.a%0d", i), 2'b11, 1'b1, 1'b0);
            chk($sformatf("b2b.rdy_lo%0d", i), {15'd0, word_ready}, 16'd0);
            chk($sformatf("b2b.busy%0d", i), {15'd0, busy}, 16'd1);
        end
        @(negedge clk);
        chk("b2b.rdy_back", {15'd0, word_ready}, 16'd1);
        chk_word("b2b.b", 16'h0000);
        @(negedge clk); chk_idle("b2b.end", 1'b1);

        // ---- starvation
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_idle($sformatf("starve%0d", i), 1'b1);
        end

        // ---- backpressure: valid held high across three words
        ws[0] = 16'hA5C3;
        ws[1] = 16'h0F96;
        ws[2] = 16'h3C69;
        word_valid = 1'b1;
        word_in    = ws[0];
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            cur = ws[k/8];
            chk_sym($sformatf("bp.s%0d", k), cur[15-2*(k%8) -: 2], 1'b1, (k % 8) == 0);
            if (k >= 1 && k <= 7)
                chk($sformatf("bp.rdy%0d", k), {15'd0, word_ready}, 16'd0);
            if (k == 8)
                chk("bp.rdy8", {15'd0, word_ready}, 16'd1);
            if (k == 9)
                chk("bp.rdy9", {15'd0, word_ready}, 16'd0);
            if (k == 0) word_in = ws[1];
            if (k == 1) word_in = ws[2];
            if (k == 9) word_valid = 1'b0;
        end
        @(negedge clk); chk_idle("bp.end", 1'b1);

        // ---- reset mid-word with the hold entry full
        word_valid = 1'b1;
        word_in    = 16'h5555;
        @(negedge clk);
        word_in = 16'hAAAA;
        chk_sym("mr.s0", 2'b01, 1'b1, 1'b1);
        @(negedge clk);
        word_valid = 1'b0;
        chk("mr.hfull", {15'd0, word_ready}, 16'd0);
        @(negedge clk); chk_sym("mr.s2", 2'b01, 1'b1, 1'b0);
        @(negedge clk); chk_sym("mr.s3", 2'b01, 1'b1, 1'b0);
        #2 clr = 1'b0;
        #1 chk_idle("mr.async", 1'b0);
        @(negedge clk);
        chk_idle("mr.held", 1'b0);
        clr        = 1'b1;
        word_valid = 1'b1;
        word_in    = 16'h1BE4;
        @(negedge clk);
        chk_idle("mr.rel", 1'b1);
        @(negedge clk);
        word_valid = 1'b0;
        chk_word("mr.new", 16'h1BE4);
        @(negedge clk); chk_idle("mr.end", 1'b1);
        @(negedge clk); chk_idle("mr.end2", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
